// File: rtl/vga_scan_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_scan_pkg : default 800x480 timing, sync windows and prefetch FSM states
// Revision 1.0
// ----------------------------------------------------------------------------
package vga_scan_pkg;

  localparam int c_h_active = 800;
  localparam int c_h_fp     = 40;
  localparam int c_h_sync   = 48;
  localparam int c_h_bp     = 88;
  localparam int c_v_active = 480;
  localparam int c_v_fp     = 13;
  localparam int c_v_sync   = 3;
  localparam int c_v_bp     = 29;
  localparam bit c_sync_pol = 1'b0;
  localparam int c_cw       = 11;

  localparam int c_h_total  = c_h_active + c_h_fp + c_h_sync + c_h_bp;
  localparam int c_v_total  = c_v_active + c_v_fp + c_v_sync + c_v_bp;

  localparam int c_hs_start = c_h_active + c_h_fp;
  localparam int c_hs_end   = c_hs_start + c_h_sync;
  localparam int c_vs_start = c_v_active + c_v_fp;
  localparam int c_vs_end   = c_vs_start + c_v_sync;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } pf_state_e;

endpackage
`default_nettype wire

// File: rtl/vga_pix_ce.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_pix_ce : divide-by-2 pixel enable, phase reset while disabled
// Revision 1.0
// ----------------------------------------------------------------------------
module vga_pix_ce (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_ce
);

  logic r_ce;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ce <= 1'b0;
    end else if (!i_en) begin
      r_ce <= 1'b0;
    end else begin
      r_ce <= ~r_ce;
    end
  end

  assign o_ce = r_ce;

endmodule
`default_nettype wire

// File: rtl/vga_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_scan_ctrl : VGA scan counters, sync/DE decode and line-prefetch sequencer
// Revision 1.0
// ----------------------------------------------------------------------------
module vga_scan_ctrl
  import vga_scan_pkg::*;
#(
  parameter int H_ACTIVE = c_h_active,
  parameter int H_FP     = c_h_fp,
  parameter int H_SYNC   = c_h_sync,
  parameter int H_BP     = c_h_bp,
  parameter int V_ACTIVE = c_v_active,
  parameter int V_FP     = c_v_fp,
  parameter int V_SYNC   = c_v_sync,
  parameter int V_BP     = c_v_bp,
  parameter bit SYNC_POL = c_sync_pol,
  parameter int CW       = c_cw
) (
  input  logic          CLOCK_50,
  input  logic          reset_n,
  input  logic          en,
  input  logic          line_ack,
  input  logic          clr_underrun,
  output logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_start,
  output logic          line_req,
  output logic [CW-1:0] line_addr,
  output logic          underrun
);

  localparam int c_ht = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_vt = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] c_h_last = CW'(c_ht - 1);
  localparam logic [CW-1:0] c_v_last = CW'(c_vt - 1);
  localparam logic [CW-1:0] c_h_act  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] c_v_act  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] c_hs_lo  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] c_hs_hi  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] c_vs_lo  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] c_vs_hi  = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic          w_ce;
  logic [CW-1:0] r_h, r_v;
  logic [CW-1:0] w_h_inc, w_v_inc, w_nh, w_nv;
  logic          w_de_n, w_req_trig, w_line_go, w_under_set, w_line_req;
  logic          r_de, r_hs, r_vs, r_fs, r_under;
  logic [CW-1:0] r_x, r_y, r_addr;
  pf_state_e     r_state, w_state_nxt;

  vga_pix_ce u_pix_ce (
    .i_clk   (CLOCK_50),
    .i_rst_n (reset_n),
    .i_en    (en),
    .o_ce    (w_ce)
  );

  // Next counter values; every registered output is decoded from these.
  always_comb begin
    w_h_inc = (r_h == c_h_last) ? '0 : r_h + 1'b1;
    w_v_inc = (r_v == c_v_last) ? '0 : r_v + 1'b1;
    w_nh    = r_h;
    w_nv    = r_v;
    if (!en) begin
      w_nh = '0;
      w_nv = '0;
    end else if (w_ce) begin
      w_nh = w_h_inc;
      if (r_h == c_h_last) begin
        w_nv = w_v_inc;
      end
    end
  end

  // w_v_inc is the line after the current one, since v is unchanged when h reaches H_ACTIVE.
  assign w_de_n      = en && (w_nh < c_h_act) && (w_nv < c_v_act);
  assign w_req_trig  = en && w_ce && (w_nh == c_h_act) && (w_v_inc < c_v_act);
  assign w_line_go   = en && w_ce && (w_nh == '0) && (w_nv < c_v_act);
  assign w_under_set = (r_state == ST_REQ) && (w_line_go || w_req_trig);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_req_trig) w_state_nxt = ST_REQ;
      ST_REQ:  if (!w_req_trig && line_ack) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!en) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    w_line_req = (r_state == ST_REQ);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_h     <= '0;
      r_v     <= '0;
      r_de    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_hs    <= ~SYNC_POL;
      r_vs    <= ~SYNC_POL;
      r_fs    <= 1'b0;
      r_addr  <= '0;
      r_under <= 1'b0;
    end else begin
      r_h  <= w_nh;
      r_v  <= w_nv;
      r_de <= w_de_n;
      r_x  <= w_de_n ? w_nh : '0;
      r_y  <= w_de_n ? w_nv : '0;
      r_hs <= (en && (w_nh >= c_hs_lo) && (w_nh < c_hs_hi)) ? SYNC_POL : ~SYNC_POL;
      r_vs <= (en && (w_nv >= c_vs_lo) && (w_nv < c_vs_hi)) ? SYNC_POL : ~SYNC_POL;
      r_fs <= en && (w_nh == '0) && (w_nv == '0);
      if (!en) begin
        r_addr <= '0;
      end else if (w_req_trig) begin
        r_addr <= w_v_inc;
      end
      if (w_under_set) begin
        r_under <= 1'b1;
      end else if (clr_underrun) begin
        r_under <= 1'b0;
      end
    end
  end

  assign pix_ce      = w_ce;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign frame_start = r_fs;
  assign line_req    = w_line_req;
  assign line_addr   = r_addr;
  assign underrun    = r_under;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vga_scan_ctrl : directed vector bench on a reduced 40x20 scan raster
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_vga_scan_ctrl;

  localparam int HA = 20, HF = 4, HS = 6, HB = 10;
  localparam int VA = 12, VF = 2, VS = 3, VB = 3;
  localparam int CW = 11;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic          clk = 1'b0;
  logic          reset_n, en, line_ack, clr_underrun;
  logic          pix_ce, hsync, vsync, de, frame_start, line_req, underrun;
  logic [CW-1:0] x, y, line_addr;

  always #10 clk = ~clk;

  vga_scan_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .CW(CW)
  ) dut (
    .CLOCK_50     (clk),
    .reset_n      (reset_n),
    .en           (en),
    .line_ack     (line_ack),
    .clr_underrun (clr_underrun),
    .pix_ce       (pix_ce),
    .hsync        (hsync),
    .vsync        (vsync),
    .de           (de),
    .x            (x),
    .y            (y),
    .frame_start  (frame_start),
    .line_req     (line_req),
    .line_addr    (line_addr),
    .underrun     (underrun)
  );

  typedef struct {
    int f; int h; int v;
    bit de; bit hs; bit vs; int x; int y; bit fs; bit req; int addr;
  } vec_t;
  vec_t tbl [19];

  int n_chk = 0, n_fail = 0;
  int k = 0;
  bit withhold = 1'b0;
  int ack_cnt = 0;
  bit prev_req = 1'b0;
  int req_q[$];
  int first0 = -1;
  int acc_pix = 0, acc_de = 0, acc_hs = 0, acc_vs = 0, acc_fs = 0;
  int acc_un = 0, acc_xbad = 0, acc_cebad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock; samples 1 ns after the edge and accumulates per-pixel statistics.
  task automatic tick();
    int p;
    @(posedge clk);
    #1;
    k++;
    p = k / 2;
    if (pix_ce !== k[0]) acc_cebad++;
    if (pix_ce) begin
      acc_pix++;
      if (de) acc_de++;
      if (!hsync) acc_hs++;
      if (!vsync) acc_vs++;
      if (frame_start) acc_fs++;
      if (underrun) acc_un++;
      if (de && ((x != CW'(p % HT)) || (y != CW'((p / HT) % VT)))) acc_xbad++;
    end
  endtask

  // Advance to the pix_ce=1 cycle of pixel (h,v) in frame f, counted from enable.
  task automatic goto_pos(input int f, input int h, input int v);
    int tgt;
    tgt = 2 * (f * FT + v * HT + h) + 1;
    while (k < tgt) tick();
  endtask

  // Framebuffer model: acks two cycles into each request unless withheld; logs requests.
  initial begin
    line_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (line_req === 1'b1 && !prev_req) begin
        req_q.push_back(int'(line_addr));
        if (line_addr == 0 && first0 < 0) first0 = k;
      end
      prev_req = (line_req === 1'b1);
      if (line_req === 1'b1 && !withhold) begin
        ack_cnt++;
        line_ack = (ack_cnt == 2);
      end else begin
        ack_cnt  = 0;
        line_ack = 1'b0;
      end
    end
  end

  initial begin
    //            f  h   v  de hs vs  x   y  fs req addr
    tbl[0]  = '{0,  0,  0, 1, 1, 1,  0,  0, 1, 0,  0};
    tbl[1]  = '{0,  1,  0, 1, 1, 1,  1,  0, 0, 0,  0};
    tbl[2]  = '{0, 19,  0, 1, 1, 1, 19,  0, 0, 0,  0};
    tbl[3]  = '{0, 20,  0, 0, 1, 1,  0,  0, 0, 1,  1};
    tbl[4]  = '{0, 23,  0, 0, 1, 1,  0,  0, 0, 0,  1};
    tbl[5]  = '{0, 24,  0, 0, 0, 1,  0,  0, 0, 0,  1};
    tbl[6]  = '{0, 29,  0, 0, 0, 1,  0,  0, 0, 0,  1};
    tbl[7]  = '{0, 30,  0, 0, 1, 1,  0,  0, 0, 0,  1};
    tbl[8]  = '{0,  0,  1, 1, 1, 1,  0,  1, 0, 0,  1};
    tbl[9]  = '{0, 20, 10, 0, 1, 1,  0,  0, 0, 1, 11};
    tbl[10] = '{0,  5, 11, 1, 1, 1,  5, 11, 0, 0, 11};
    tbl[11] = '{0, 20, 11, 0, 1, 1,  0,  0, 0, 0, 11};
    tbl[12] = '{0,  5, 12, 0, 1, 1,  0,  0, 0, 0, 11};
    tbl[13] = '{0,  0, 14, 0, 1, 0,  0,  0, 0, 0, 11};
    tbl[14] = '{0, 26, 14, 0, 0, 0,  0,  0, 0, 0, 11};
    tbl[15] = '{0, 39, 16, 0, 1, 0,  0,  0, 0, 0, 11};
    tbl[16] = '{0,  0, 17, 0, 1, 1,  0,  0, 0, 0, 11};
    tbl[17] = '{0, 20, 19, 0, 1, 1,  0,  0, 0, 1,  0};
    tbl[18] = '{0, 39, 19, 0, 1, 1,  0,  0, 0, 0,  0};

    reset_n = 1'b0; en = 1'b0; clr_underrun = 1'b0;
    repeat (2) @(posedge clk);
    #5 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_pix_ce", pix_ce, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_de", de, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_line_req", line_req, 0);
    chk("rst_line_addr", line_addr, 0);
    chk("rst_underrun", underrun, 0);

    en = 1'b1;
    k  = 0;
    chk("en0_pix_ce", pix_ce, 0);
    chk("en0_de", de, 0);

    for (int i = 0; i < 19; i++) begin
      goto_pos(tbl[i].f, tbl[i].h, tbl[i].v);
      chk($sformatf("v%0d_pix_ce", i), pix_ce, 1);
      chk($sformatf("v%0d_de", i), de, tbl[i].de);
      chk($sformatf("v%0d_hsync", i), hsync, tbl[i].hs);
      chk($sformatf("v%0d_vsync", i), vsync, tbl[i].vs);
      chk($sformatf("v%0d_x", i), x, tbl[i].x);
      chk($sformatf("v%0d_y", i), y, tbl[i].y);
      chk($sformatf("v%0d_frame_start", i), frame_start, tbl[i].fs);
      chk($sformatf("v%0d_line_req", i), line_req, tbl[i].req);
      chk($sformatf("v%0d_line_addr", i), line_addr, tbl[i].addr);
      chk($sformatf("v%0d_underrun", i), underrun, 0);
    end

    // Whole first frame statistics.
    chk("frm_pix_ce_count", acc_pix, FT);
    chk("frm_pix_ce_phase_errs", acc_cebad, 0);
    chk("frm_de_count", acc_de, HA * VA);
    chk("frm_hsync_count", acc_hs, HS * VT);
    chk("frm_vsync_count", acc_vs, VS * HT);
    chk("frm_frame_start_count", acc_fs, 1);
    chk("frm_underrun_count", acc_un, 0);
    chk("frm_xy_errs", acc_xbad, 0);
    chk("frm_req_count", req_q.size(), VA);
    for (int i = 0; i < req_q.size() && i < VA; i++) begin
      chk($sformatf("frm_req%0d_addr", i), req_q[i], (i + 1) % VA);
    end
    chk("req0_v", (first0 / 2) / HT, VT - 1);
    chk("req0_h", (first0 / 2) % HT, HA);

    // Withheld ack for the request issued on line 3.
    goto_pos(1, 0, 3);
    withhold = 1'b1;
    goto_pos(1, 0, 4);
    chk("ur_set", underrun, 1);
    chk("ur_req_held", line_req, 1);
    chk("ur_addr", line_addr, 4);
    withhold = 1'b0;
    goto_pos(1, 5, 4);
    chk("ur_req_acked", line_req, 0);
    chk("ur_sticky", underrun, 1);
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    chk("ur_cleared", underrun, 0);

    // Retrigger while still requesting, with clear on the same edge.
    withhold = 1'b1;
    goto_pos(1, 2, 5);
    chk("ur_l5_set", underrun, 1);
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    chk("ur_l5_cleared", underrun, 0);
    goto_pos(1, 19, 5);
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    chk("retrig_set_wins", underrun, 1);
    chk("retrig_req", line_req, 1);
    chk("retrig_addr", line_addr, 6);

    // Scan disabled mid-frame with a request pending.
    goto_pos(1, 10, 6);
    chk("dis_pre_req", line_req, 1);
    en = 1'b0;
    tick();
    chk("dis_pix_ce", pix_ce, 0);
    chk("dis_line_req", line_req, 0);
    chk("dis_de", de, 0);
    chk("dis_x", x, 0);
    chk("dis_y", y, 0);
    chk("dis_hsync", hsync, 1);
    chk("dis_vsync", vsync, 1);
    chk("dis_frame_start", frame_start, 0);
    chk("dis_line_addr", line_addr, 0);
    chk("dis_underrun_held", underrun, 1);
    withhold = 1'b0;
    repeat (3) tick();

    en = 1'b1;
    k  = 0;
    tick();
    chk("reen_pix_ce", pix_ce, 1);
    chk("reen_frame_start", frame_start, 1);
    chk("reen_de", de, 1);

    // Asynchronous reset between edges while a request is pending.
    withhold = 1'b1;
    goto_pos(0, 3, 1);
    chk("ar_pre_req", line_req, 1);
    chk("ar_pre_de", de, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("ar_line_req", line_req, 0);
    chk("ar_de", de, 0);
    chk("ar_pix_ce", pix_ce, 0);
    chk("ar_y", y, 0);
    chk("ar_hsync", hsync, 1);
    chk("ar_vsync", vsync, 1);
    chk("ar_underrun", underrun, 0);
    en = 1'b0;
    withhold = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
